// File: rtl/tlul_sram_adapter_pkg.sv
// Shared TL-UL types, opcodes and helpers for the SRAM adapter.
package tlul_sram_adapter_pkg;

    localparam logic [31:0] MemBase = 32'h8000_0000;

    // A-channel opcodes
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    // D-channel opcodes
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // One queued response: everything needed to build the D beat except data.
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] size;
        logic [7:0] source;
        logic       error;
    } rsp_t;

    // Byte lanes covered by a transfer of 2^size bytes at the given word offset.
    function automatic logic [3:0] lane_window(input logic [1:0] size, input logic [1:0] offs);
        case (size)
            2'd0:    return 4'b0001 << offs;
            2'd1:    return offs[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/tlul_sram_adapter_rsp_fifo.sv
// In-order response queue. Entries are pushed at accept time; the SRAM read
// data for the entry pushed in cycle N is written into it in cycle N+1 and
// is bypassed to the head output in that same cycle.
module tlul_rsp_fifo
    import tlul_sram_adapter_pkg::*;
#(
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  rsp_t            push_rsp_i,
    input  logic            pop_i,
    input  logic [31:0]     cap_data_i,
    output logic [CntW-1:0] count_o,
    output logic            head_valid_o,
    output rsp_t            head_rsp_o,
    output logic [31:0]     head_data_o
);
    localparam int PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, cap_ptr_q, cap_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Depth-1:0] vld_q, vld_d;
    logic             cap_pend_q, cap_pend_d;
    rsp_t             rsp_q  [Depth];
    rsp_t             rsp_d  [Depth];
    logic [31:0]      data_q [Depth];
    logic [31:0]      data_d [Depth];
    logic [31:0]      cap_val;

    // Only a successful Get carries read data; everything else answers with 0.
    assign cap_val = (rsp_q[cap_ptr_q].opcode == Get && !rsp_q[cap_ptr_q].error) ? cap_data_i : '0;

    // Next-state: capture last cycle's read, then pop, then push.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        vld_d      = vld_q;
        rsp_d      = rsp_q;
        data_d     = data_q;
        cap_pend_d = push_i;
        cap_ptr_d  = wptr_q;
        if (cap_pend_q) data_d[cap_ptr_q] = cap_val;
        if (pop_i) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + PtrW'(1);
        end
        if (push_i) begin
            vld_d[wptr_q] = 1'b1;
            rsp_d[wptr_q] = push_rsp_i;
            wptr_d        = wptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end

    // State registers; reset drops every queued response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cap_ptr_q  <= '0;
            count_q    <= '0;
            vld_q      <= '0;
            cap_pend_q <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                rsp_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cap_ptr_q  <= cap_ptr_d;
            count_q    <= count_d;
            vld_q      <= vld_d;
            cap_pend_q <= cap_pend_d;
            rsp_q      <= rsp_d;
            data_q     <= data_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = vld_q[rptr_q];
    assign head_rsp_o   = rsp_q[rptr_q];
    assign head_data_o  = (cap_pend_q && cap_ptr_q == rptr_q) ? cap_val : data_q[rptr_q];

endmodule

// File: rtl/tlul_sram_adapter.sv
// TL-UL device front-end for a single-port SRAM with 1-cycle read latency.
// Requests are checked inline; illegal ones are acknowledged with d_error
// and never reach the SRAM.
module tlul_sram_adapter
    import tlul_sram_adapter_pkg::*;
#(
    parameter int MemWords    = 16384,
    parameter int Outstanding = 2,
    localparam int AddrW      = $clog2(MemWords)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  tl_h2d_t          tl_i,
    output tl_d2h_t          tl_o,
    output logic             req_o,
    output logic             we_o,
    output logic [AddrW-1:0] addr_o,
    output logic [31:0]      wdata_o,
    output logic [31:0]      wmask_o,
    input  logic [31:0]      rdata_i
);
    logic [$clog2(Outstanding+1)-1:0] count;
    logic       a_ready, accept, a_err, d_valid, pop;
    logic       op_bad, size_bad, addr_bad, align_bad, mask_bad;
    logic [3:0] lanes;
    rsp_t       push_rsp, head_rsp;
    logic [31:0] head_data;
    logic       head_valid;
    logic       unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:30]};

    // Request legality; any failing check turns the access into an error ack.
    always_comb begin
        op_bad    = !(tl_i.a_opcode == Get || tl_i.a_opcode == PutFullData ||
                      tl_i.a_opcode == PutPartialData);
        size_bad  = tl_i.a_size > 2'd2;
        addr_bad  = 32'(tl_i.a_address[29:2]) >= 32'(MemWords);
        align_bad = (tl_i.a_size == 2'd1 && tl_i.a_address[0]) ||
                    (tl_i.a_size == 2'd2 && |tl_i.a_address[1:0]);
        lanes     = lane_window(tl_i.a_size, tl_i.a_address[1:0]);
        // PutFull must cover its window exactly; others only stay inside it.
        if (tl_i.a_opcode == PutFullData) mask_bad = tl_i.a_mask != lanes;
        else                              mask_bad = |(tl_i.a_mask & ~lanes);
        a_err = op_bad | size_bad | addr_bad | align_bad | mask_bad;
    end

    // Handshake and SRAM strobe; a_ready depends only on registered count.
    always_comb begin
        a_ready = !rst_i && (32'(count) < 32'(Outstanding));
        accept  = tl_i.a_valid && a_ready;
        req_o   = accept && !a_err;
        we_o    = req_o && (tl_i.a_opcode != Get);
        addr_o  = rst_i ? '0 : tl_i.a_address[AddrW+1:2];
        wdata_o = rst_i ? '0 : tl_i.a_data;
        wmask_o = '0;
        for (int b = 0; b < 4; b++) wmask_o[8*b +: 8] = {8{tl_i.a_mask[b] && !rst_i}};
        push_rsp.opcode = tl_i.a_opcode;
        push_rsp.size   = tl_i.a_size;
        push_rsp.source = tl_i.a_source;
        push_rsp.error  = a_err;
    end

    assign d_valid = head_valid && !rst_i;
    assign pop     = d_valid && tl_i.d_ready;

    tlul_rsp_fifo #(.Depth(Outstanding)) u_rsp_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (accept),
        .push_rsp_i   (push_rsp),
        .pop_i        (pop),
        .cap_data_i   (rdata_i),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_rsp_o   (head_rsp),
        .head_data_o  (head_data)
    );

    // D channel built from the queue head; fields held at 0 when idle.
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = (head_rsp.opcode == Get) ? AccessAckData : AccessAck;
            tl_o.d_size   = head_rsp.size;
            tl_o.d_source = head_rsp.source;
            tl_o.d_error  = head_rsp.error;
            tl_o.d_data   = head_data;
        end
    end

endmodule

// File: tb/tb_tlul_sram_adapter.sv
// Directed bench for tlul_sram_adapter with a transaction-level reference
// model (byte-addressed memory image plus a response queue).
module tb_tlul_sram_adapter;
    import tlul_sram_adapter_pkg::*;

    localparam int MemWords = 16384;

    logic        clk = 1'b0;
    logic        rst;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        req_o, we_o;
    logic [13:0] addr_o;
    logic [31:0] wdata_o, wmask_o, rdata;

    int tests = 0;
    int fails = 0;

    tlul_sram_adapter #(.MemWords(MemWords), .Outstanding(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .req_o   (req_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .wmask_o (wmask_o),
        .rdata_i (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- SRAM behavioural model (environment) ----------------
    logic [31:0] sram [MemWords];
    initial begin
        logic        r, w;
        logic [13:0] a;
        logic [31:0] d, m;
        for (int i = 0; i < MemWords; i++) sram[i] = 32'hA500_0000 ^ i;
        rdata = '0;
        forever begin
            @(negedge clk);
            r = req_o; w = we_o; a = addr_o; d = wdata_o; m = wmask_o;
            @(posedge clk);
            if (r) begin
                if (w) sram[a] <= (sram[a] & ~m) | (d & m);
                else   rdata   <= sram[a];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
        logic [2:0]  op;
        int          cyc;
    } log_t;

    exp_t        exp_q[$];
    log_t        log_q[$];
    logic [31:0] ref_mem [MemWords];
    int          acc_cyc [256];
    int          cyc = 0;
    int          ardy_low = 0;
    int          req_cnt = 0;

    function automatic bit model_err(input logic [2:0] op, input logic [1:0] size,
                                     input logic [31:0] addr, input logic [3:0] mask);
        logic [3:0] cov;
        int         off, n;
        if (!(op == 3'd4 || op == 3'd0 || op == 3'd1)) return 1;
        if (size > 2) return 1;
        if (int'(addr[29:2]) >= MemWords) return 1;
        n   = 1 << size;
        off = int'(addr[1:0]);
        if (off % n != 0) return 1;
        cov = '0;
        for (int b = 0; b < 4; b++) if (b >= off && b < off + n) cov[b] = 1'b1;
        if (op == 3'd0 && mask != cov) return 1;
        if ((mask & ~cov) != 4'h0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] mask);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (mask[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        logic        e_rdy, s_acc, s_err, s_pop, e_req;
        tl_h2d_t     s_a;
        exp_t        h, ne;
        logic [13:0] w;
        for (int i = 0; i < MemWords; i++) ref_mem[i] = 32'hA500_0000 ^ i;
        forever begin
            @(negedge clk);
            e_rdy = !rst && exp_q.size() < 2;
            chk("a_ready", tl_o.a_ready, e_rdy);
            chk("d_valid", tl_o.d_valid, !rst && exp_q.size() > 0);
            if (!rst && exp_q.size() > 0) begin
                h = exp_q[0];
                chk("d_opcode", tl_o.d_opcode, (h.op == 3'd4) ? 1 : 0);
                chk("d_size",   tl_o.d_size, h.size);
                chk("d_source", tl_o.d_source, h.src);
                chk("d_error",  tl_o.d_error, h.err);
                chk("d_data",   tl_o.d_data, h.data);
                chk("d_misc",   {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
            end
            s_a   = tl_i;
            s_acc = s_a.a_valid && e_rdy;
            s_err = model_err(s_a.a_opcode, s_a.a_size, s_a.a_address, s_a.a_mask);
            e_req = s_acc && !s_err;
            chk("req_o", req_o, e_req);
            if (e_req) begin
                chk("we_o",    we_o, s_a.a_opcode != 3'd4);
                chk("addr_o",  addr_o, s_a.a_address[15:2]);
                chk("wdata_o", wdata_o, s_a.a_data);
                chk("wmask_o", wmask_o, byte_mask(s_a.a_mask));
            end
            s_pop = !rst && exp_q.size() > 0 && s_a.d_ready;
            if (s_pop) log_q.push_back('{exp_q[0].src, exp_q[0].data, exp_q[0].err, exp_q[0].op, cyc});
            if (s_a.a_valid && !tl_o.a_ready) ardy_low++;
            if (req_o) req_cnt++;
            @(posedge clk);
            if (rst) exp_q.delete();
            else begin
                if (s_pop) void'(exp_q.pop_front());
                if (s_acc) begin
                    w       = s_a.a_address[15:2];
                    ne.op   = s_a.a_opcode;
                    ne.size = s_a.a_size;
                    ne.src  = s_a.a_source;
                    ne.err  = s_err;
                    ne.data = (s_a.a_opcode == 3'd4 && !s_err) ? ref_mem[w] : 32'h0;
                    if (!s_err && s_a.a_opcode != 3'd4)
                        for (int b = 0; b < 4; b++)
                            if (s_a.a_mask[b]) ref_mem[w][8*b +: 8] = s_a.a_data[8*b +: 8];
                    acc_cyc[s_a.a_source] = cyc;
                    exp_q.push_back(ne);
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic        snap_req, snap_we;
    logic [13:0] snap_addr;
    logic [31:0] snap_wmask;

    task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        logic acc = 1'b0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = sz;
        tl_i.a_source  = src;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc        = tl_o.a_ready;
            snap_req   = req_o;
            snap_we    = we_o;
            snap_addr  = addr_o;
            snap_wmask = wmask_o;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", acc, 1);
        tl_i.a_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_done", exp_q.size(), 0);
    endtask

    function automatic int log_idx(input logic [7:0] src);
        for (int i = log_q.size() - 1; i >= 0; i--) if (log_q[i].src == src) return i;
        return -1;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int i0, n;
        tl_i         = '0;
        tl_i.d_ready = 1'b1;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", tl_o.a_ready, 0);
        chk("rst_d_valid", tl_o.d_valid, 0);
        chk("rst_req",     req_o, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_a_ready", tl_o.a_ready, 1);

        // Full-word write then read back
        send(PutFullData, 2'd2, 8'h11, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
        chk("t1_req",   snap_req, 1);
        chk("t1_we",    snap_we, 1);
        chk("t1_addr",  snap_addr, 4);
        chk("t1_wmask", snap_wmask, 32'hFFFF_FFFF);
        send(Get, 2'd2, 8'h12, 32'h8000_0010, 4'hF, 32'h0);
        chk("t1_get_we", snap_we, 0);
        drain();
        i0 = log_idx(8'h12);
        chk("t1_found", i0 >= 0, 1);
        if (i0 >= 0) begin
            chk("t1_data",    log_q[i0].data, 32'hDEAD_BEEF);
            chk("t1_op",      log_q[i0].op, 3'd4);
            chk("t1_err",     log_q[i0].err, 0);
            chk("t1_latency", log_q[i0].cyc - acc_cyc[8'h12], 1);
        end

        // Partial byte write merges into existing word
        send(PutFullData, 2'd2, 8'h13, 32'h8000_0010, 4'hF, 32'h1122_3344);
        send(PutPartialData, 2'd0, 8'h14, 32'h8000_0012, 4'b0100, 32'h00AB_0000);
        chk("t2_wmask", snap_wmask, 32'h00FF_0000);
        send(Get, 2'd2, 8'h15, 32'h8000_0010, 4'hF, 32'h0);
        drain();
        i0 = log_idx(8'h15);
        chk("t2_found", i0 >= 0, 1);
        if (i0 >= 0) chk("t2_data", log_q[i0].data, 32'h11AB_3344);
        chk("t2_model_mem", ref_mem[4], 32'h11AB_3344);

        // Eight back-to-back reads at full rate
        ardy_low = 0;
        for (int i = 0; i < 8; i++) send(Get, 2'd2, 8'(i), 32'h8000_0000 + 32'(4 * i), 4'hF, 32'h0);
        drain();
        chk("t3_no_stall", ardy_low, 0);
        i0 = log_idx(8'h00);
        chk("t3_found", (i0 >= 0) && (i0 + 8 <= log_q.size()), 1);
        if (i0 >= 0 && i0 + 8 <= log_q.size()) begin
            for (int i = 0; i < 8; i++) begin
                chk("t3_order", log_q[i0+i].src, i);
                chk("t3_consec", log_q[i0+i].cyc - log_q[i0].cyc, i);
            end
            chk("t3_data1", log_q[i0+1].data, 32'hA500_0001);
            chk("t3_data4", log_q[i0+4].data, 32'h11AB_3344);
        end

        // Backpressure: third request waits for the first pop
        tl_i.d_ready = 1'b0;
        fork
            begin
                send(Get, 2'd2, 8'h20, 32'h8000_0020, 4'hF, 32'h0);
                send(Get, 2'd2, 8'h21, 32'h8000_0024, 4'hF, 32'h0);
                send(Get, 2'd2, 8'h22, 32'h8000_0028, 4'hF, 32'h0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("t4_full",    tl_o.a_ready, 0);
                chk("t4_head_v",  tl_o.d_valid, 1);
                chk("t4_head_id", tl_o.d_source, 8'h20);
                @(posedge clk);
                #1 tl_i.d_ready = 1'b1;
            end
        join
        drain();
        i0 = log_idx(8'h20);
        chk("t4_found", i0 >= 0, 1);
        if (i0 >= 0) chk("t4_third_after_pop", acc_cyc[8'h22], log_q[i0].cyc + 1);

        // Illegal requests: error acks, no SRAM access
        req_cnt = 0;
        send(3'd3, 2'd2, 8'h40, 32'h8000_0010, 4'hF, 32'h1);
        send(Get, 2'd3, 8'h41, 32'h8000_0010, 4'hF, 32'h0);
        send(Get, 2'd2, 8'h42, 32'h8004_0000, 4'hF, 32'h0);
        send(PutFullData, 2'd2, 8'h43, 32'h8000_0010, 4'h7, 32'h5555_5555);
        drain();
        chk("t5_no_req", req_cnt, 0);
        for (int s = 8'h40; s <= 8'h43; s++) begin
            i0 = log_idx(8'(s));
            chk("t5_found", i0 >= 0, 1);
            if (i0 >= 0) chk("t5_err", log_q[i0].err, 1);
        end
        send(Get, 2'd2, 8'h44, 32'h8000_0010, 4'hF, 32'h0);
        drain();
        i0 = log_idx(8'h44);
        chk("t5_found_rd", i0 >= 0, 1);
        if (i0 >= 0) chk("t5_mem_kept", log_q[i0].data, 32'h11AB_3344);

        // Asynchronous reset with two responses queued
        tl_i.d_ready = 1'b0;
        send(Get, 2'd2, 8'h50, 32'h8000_0010, 4'hF, 32'h0);
        send(Get, 2'd2, 8'h51, 32'h8000_0014, 4'hF, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_d_valid", tl_o.d_valid, 0);
        chk("t6_a_ready", tl_o.a_ready, 0);
        chk("t6_req",     req_o, 0);
        n = log_q.size();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tl_i.d_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_stale", log_q.size(), n);
        chk("t6_a_ready_back", tl_o.a_ready, 1);
        send(Get, 2'd2, 8'h52, 32'h8000_0010, 4'hF, 32'h0);
        drain();
        i0 = log_idx(8'h52);
        chk("t6_found", i0 >= 0, 1);
        if (i0 >= 0) chk("t6_data", log_q[i0].data, 32'h11AB_3344);
        chk("t6_dropped", log_idx(8'h50), 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tlul_sram_adapter.md
Name: tlul_sram_adapter

Overview:
- TL-UL device that terminates the crossbar's memory port (0x80000000–0xBFFFFFFF window) and drives a single-port synchronous SRAM with 1-cycle read latency.
- Accepts Get/PutFullData/PutPartialData and returns AccessAck/AccessAckData in order.
- Buffers up to Outstanding responses so back-to-back transfers run at one per cycle.
- Illegal requests get d_error responses and never touch the SRAM.

Parameters:
- MemWords, 16384, SRAM depth in 32-bit words (64 KiB); power of two.
- Outstanding, 2, response FIFO depth; ≥2 for full throughput, power of two.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- tl_i  in  tl_h2d_t  A channel plus d_ready from the crossbar
- tl_o  out  tl_d2h_t  D channel plus a_ready to the crossbar
- req_o  out  1  SRAM access strobe
- we_o  out  1  1 = write, 0 = read
- addr_o  out  $clog2(MemWords)  word address = a_address[$clog2(MemWords)+1:2]
- wdata_o  out  32  write data = a_data
- wmask_o  out  32  bit-enable, each a_mask bit expanded ×8
- rdata_i  in  32  read data, valid the cycle after a read strobe

Behaviour:
- Reset (async assert, sync release): count, pointers and FIFO valid bits cleared. While rst_i=1: a_ready=0, d_valid=0, req_o=0; all other outputs are don't-care but driven 0. Reset mid-transfer discards every pending response.
- a_ready = (count < Outstanding), from registered count only. No combinational path from d_ready to a_ready.
- Accept = a_valid & a_ready, in cycle N:
  - Push {opcode, size, source, error} into the FIFO.
  - If not an error: req_o=1 in the same cycle, we_o=(opcode!=Get).
- Read data: rdata_i sampled at N+1 into the entry pushed at N.
- Error (request accepted, no SRAM access, d_error=1), checked in priority order:
  - opcode not in {Get=4, PutFull=0, PutPartial=1}
  - a_size>2
  - a_address[29:2] ≥ MemWords
  - a_address not aligned to 2^a_size
  - PutFull mask not exactly the bytes covered by size/address (size 0 one bit, size 1 bits {1:0} or {3:2}, size 2 4'hF)
  - mask bits outside the addressed lanes
  - Get and PutPartial masks only checked for lanes ⊆ size window
- D channel:
  - d_valid = head entry present and its data captured, so earliest d_valid is N+1.
  - d_opcode = AccessAckData(1) for Get, else AccessAck(0).
  - d_size and d_source echo the request; d_param=0, d_sink=0.
  - d_data = captured rdata for a successful Get, else 0.
  - d_user = default (no integrity).
- Pop on d_valid & d_ready. The head holds stable while d_ready=0.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Full: a_ready=0 until a pop; a pop in cycle N raises a_ready in N+1.
- Pointers wrap modulo Outstanding; count range 0..Outstanding.
- Ordering: responses always in acceptance order, including error entries.
- Throughput: with d_ready held high, one response per cycle sustained. Latency A-accept → d_valid = 1 cycle.

Decomposition:
- tlul_pkg (existing): opcode constants Get/PutFullData/PutPartialData/AccessAck/AccessAckData, tl_h2d_t/tl_d2h_t.
- Add to top_pkg: localparam MemBase = 32'h8000_0000.
- One sub-module: tlul_rsp_fifo (parametric-depth FIFO of response records with separate data-capture write port). Request checking stays inline.

Test Plan:
- PutFull addr 0x80000010 size 2 mask F data 0xDEADBEEF, then Get same → req_o/we_o=1, addr_o=4, wmask_o=0xFFFFFFFF; Get returns AccessAckData, d_data=0xDEADBEEF, d_error=0, d_valid 1 cycle after accept.
- PutPartial addr 0x80000012 size 0 mask 0100 data 0x00AB0000 over 0x11223344, then Get → d_data=0x11AB3344.
- Back-to-back 8 Gets, d_ready=1 → a_ready never drops, 8 consecutive d_valid cycles, sources 0..7 in order.
- d_ready=0 with 3 Gets offered → 2 accepted, a_ready=0 on 3rd, head stable; raise d_ready → 3rd accepted the cycle after first pop.
- Errors: opcode 3, size 3, addr 0x80040000 (word 65536), PutFull size 2 mask 0x7 → each d_error=1, req_o never asserted, SRAM contents unchanged.
- Assert rst_i asynchronously with 2 responses queued → d_valid and a_ready drop immediately; after release a_ready=1, no stale response emitted.
